// File: rtl/mem_stage_ob.sv
// MEM stage in-order buffer: holds EXE handoffs until their bus response arrives,
// then delivers them to WB in program order. Cancelled responses are dropped via a discard count.
module mem_stage_ob_entry #(
    parameter int INFO_W = 38
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr,
    input  logic              clr,
    input  logic              cpl,
    input  logic [INFO_W-1:0] in_info,
    input  logic [31:0]       in_res,
    input  logic [3:0]        in_ld,
    input  logic [6:0]        in_exc,
    input  logic              in_wait,
    input  logic [31:0]       rdata,
    output logic              vld,
    output logic              done,
    output logic              is_ld,
    output logic [INFO_W-1:0] info,
    output logic [31:0]       wdata,
    output logic [6:0]        exc
);
    logic [3:0]  ld;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] ld_data;

    // wdata holds the access address until the load data replaces it
    always_comb begin
        b = rdata[{wdata[1:0], 3'b000} +: 8];
        h = wdata[1] ? rdata[31:16] : rdata[15:0];
        if (ld[3])      ld_data = {{24{ld[0] & b[7]}}, b};
        else if (ld[2]) ld_data = {{16{ld[0] & h[15]}}, h};
        else            ld_data = rdata;
    end

    assign is_ld = |ld;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld   <= 1'b0;
            done  <= 1'b0;
            ld    <= '0;
            info  <= '0;
            wdata <= '0;
            exc   <= '0;
        end else if (wr) begin
            vld   <= 1'b1;
            done  <= ~in_wait;
            ld    <= in_ld;
            info  <= in_info;
            wdata <= in_res;
            exc   <= in_exc;
        end else if (clr) begin
            vld  <= 1'b0;
            done <= 1'b0;
        end else if (cpl) begin
            done <= 1'b1;
            if (|ld) wdata <= ld_data;
        end
    end
endmodule

module mem_stage_ob #(
    parameter int DEPTH  = 2,
    parameter int INFO_W = 38
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              exe_valid,
    output logic              mem_allowin,
    input  logic [INFO_W-1:0] exe_info,
    input  logic [31:0]       exe_result,
    input  logic [3:0]        exe_ld,
    input  logic              exe_st,
    input  logic [6:0]        exe_exc,
    input  logic              data_ok,
    input  logic [31:0]       rdata,
    input  logic              cancel,
    input  logic              wb_allowin,
    output logic              mem_to_wb_valid,
    output logic [INFO_W-1:0] mem_info,
    output logic [31:0]       mem_wdata,
    output logic [6:0]        mem_exc,
    output logic              mem_exc_flush,
    output logic              mem_fwd_pending
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] head, tail, tgt, idx;
    logic [PW:0]   count, discard, nwait, nwait_after;
    logic          dbg_err;
    logic          enq, deq, found, cpl_go, drop, in_wait, hv;

    logic [DEPTH-1:0]             vld, done, is_ld;
    logic [DEPTH-1:0][INFO_W-1:0] ent_info;
    logic [DEPTH-1:0][31:0]       ent_wdata;
    logic [DEPTH-1:0][6:0]        ent_exc;

    assign hv              = vld[head];
    assign mem_to_wb_valid = hv & done[head];
    assign mem_info        = hv ? ent_info[head]  : '0;
    assign mem_wdata       = hv ? ent_wdata[head] : '0;
    assign mem_exc         = hv ? ent_exc[head]   : '0;
    assign mem_exc_flush   = hv & (|ent_exc[head]);
    assign mem_fwd_pending = |(vld & ~done & is_ld);

    assign deq         = mem_to_wb_valid & wb_allowin;
    assign mem_allowin = (count < (PW+1)'(DEPTH)) | deq;
    assign enq         = exe_valid & mem_allowin & ~cancel;
    assign in_wait     = ((|exe_ld) | exe_st) & (exe_exc == 7'd0);
    assign drop        = data_ok & (discard != '0);
    assign cpl_go      = data_ok & (discard == '0) & found;

    // Oldest waiting entry: scan from youngest to oldest so the oldest wins
    always_comb begin
        found = 1'b0;
        tgt   = '0;
        idx   = '0;
        nwait = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = head + PW'(k);
            if (vld[idx] & ~done[idx]) begin
                found = 1'b1;
                tgt   = idx;
                nwait = nwait + 1'b1;
            end
        end
        nwait_after = nwait - (PW+1)'(cpl_go);
    end

    genvar i;
    generate
        for (i = 0; i < DEPTH; i++) begin : g_ent
            mem_stage_ob_entry #(.INFO_W(INFO_W)) u_ent (
                .clk     (clk),
                .resetn  (resetn),
                .wr      (enq & (tail == PW'(i))),
                .clr     (cancel | (deq & (head == PW'(i)))),
                .cpl     (cpl_go & (tgt == PW'(i))),
                .in_info (exe_info),
                .in_res  (exe_result),
                .in_ld   (exe_ld),
                .in_exc  (exe_exc),
                .in_wait (in_wait),
                .rdata   (rdata),
                .vld     (vld[i]),
                .done    (done[i]),
                .is_ld   (is_ld[i]),
                .info    (ent_info[i]),
                .wdata   (ent_wdata[i]),
                .exc     (ent_exc[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            discard <= '0;
            dbg_err <= 1'b0;
        end else begin
            if (cancel) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PW'(deq);
                tail  <= tail + PW'(enq);
                count <= count + (PW+1)'(enq) - (PW+1)'(deq);
            end
            // A response completing an entry on the cancel edge is not owed a drop
            discard <= discard - (PW+1)'(drop) + (cancel ? nwait_after : '0);
            if (data_ok & (discard == '0) & ~found) dbg_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_stage_ob.sv
// Scoreboard bench for mem_stage_ob: directed vectors push expected WB payloads,
// a negedge monitor pops and compares on each accepted delivery.
module tb_mem_stage_ob;
    logic        clk = 0, resetn = 0;
    logic        exe_valid = 0, exe_st = 0, data_ok = 0, cancel = 0, wb_allowin = 1;
    logic [37:0] exe_info = '0;
    logic [31:0] exe_result = '0, rdata = '0;
    logic [3:0]  exe_ld = '0;
    logic [6:0]  exe_exc = '0;
    logic        mem_allowin, mem_to_wb_valid, mem_exc_flush, mem_fwd_pending;
    logic [37:0] mem_info;
    logic [31:0] mem_wdata;
    logic [6:0]  mem_exc;

    int total = 0, bad = 0;

    typedef struct {
        logic [37:0] info;
        logic [31:0] wdata;
        logic [6:0]  exc;
    } exp_t;
    exp_t q[$];

    mem_stage_ob dut (
        .clk(clk), .resetn(resetn), .exe_valid(exe_valid), .mem_allowin(mem_allowin),
        .exe_info(exe_info), .exe_result(exe_result), .exe_ld(exe_ld), .exe_st(exe_st),
        .exe_exc(exe_exc), .data_ok(data_ok), .rdata(rdata), .cancel(cancel),
        .wb_allowin(wb_allowin), .mem_to_wb_valid(mem_to_wb_valid), .mem_info(mem_info),
        .mem_wdata(mem_wdata), .mem_exc(mem_exc), .mem_exc_flush(mem_exc_flush),
        .mem_fwd_pending(mem_fwd_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [37:0] info, input logic [31:0] wd, input logic [6:0] ex);
        exp_t e;
        e.info = info; e.wdata = wd; e.exc = ex;
        q.push_back(e);
    endtask

    task automatic enq(input logic [37:0] info, input logic [31:0] res, input logic [3:0] ld,
                       input logic st, input logic [6:0] ex);
        exe_valid = 1; exe_info = info; exe_result = res; exe_ld = ld; exe_st = st; exe_exc = ex;
    endtask

    task automatic idle();
        exe_valid = 0; exe_ld = '0; exe_st = 0; exe_exc = '0;
    endtask

    task automatic wait_drain(input string nm);
        for (int n = 0; n < 20 && q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        chk(nm, q.size(), 0);
    endtask

    // Monitor: every accepted delivery must match the oldest expected entry
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && mem_to_wb_valid && wb_allowin) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL wb_unexpected: got info=%h wdata=%h exc=%h expected none",
                             mem_info, mem_wdata, mem_exc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (mem_info !== e.info || mem_wdata !== e.wdata || mem_exc !== e.exc) begin
                        bad++;
                        $display("FAIL wb_payload: got info=%h wdata=%h exc=%h expected info=%h wdata=%h exc=%h",
                                 mem_info, mem_wdata, mem_exc, e.info, e.wdata, e.exc);
                    end
                end
            end
        end
    end

    logic [3:0]  v_ld  [5] = '{4'b1001, 4'b1000, 4'b0101, 4'b0100, 4'b0010};
    logic [1:0]  v_a   [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] v_exp [5] = '{32'hFFFF_FF80, 32'h0000_0012, 32'hFFFF_80FF, 32'h0000_1234, 32'h80FF_1234};

    initial begin
        // reset state
        step(); step();
        @(negedge clk);
        chk("rst_allowin", mem_allowin, 1);
        chk("rst_valid", mem_to_wb_valid, 0);
        chk("rst_pending", mem_fwd_pending, 0);
        chk("rst_wdata", mem_wdata, 0);
        step();
        resetn = 1;

        // single loads, data_ok one cycle after enqueue, all extraction modes
        for (int v = 0; v < 5; v++) begin
            step();
            enq(38'(v + 1), {30'h400, v_a[v]}, v_ld[v], 0, 0);
            step();
            idle();
            data_ok = 1; rdata = 32'h80FF_1234;
            push(38'(v + 1), v_exp[v], 0);
            @(negedge clk);
            chk("ld_pending", mem_fwd_pending, 1);
            chk("ld_not_yet_valid", mem_to_wb_valid, 0);
            step();
            data_ok = 0;
            @(negedge clk);
            chk("ld_valid_after_ok", mem_to_wb_valid, 1);
            wait_drain("ld_drain");
        end

        // two loads fill DEPTH 2 with WB stalled; in-order delivery
        wb_allowin = 0;
        step(); enq(20, 32'h2000, 4'b0010, 0, 0);
        step(); enq(21, 32'h2004, 4'b0010, 0, 0);
        step(); idle();
        @(negedge clk);
        chk("full_allowin", mem_allowin, 0);
        step(); data_ok = 1; rdata = 32'h11; push(20, 32'h11, 0);
        step(); rdata = 32'h22; push(21, 32'h22, 0);
        step(); data_ok = 0;
        @(negedge clk);
        chk("full_done_allowin", mem_allowin, 0);
        chk("full_done_valid", mem_to_wb_valid, 1);
        step(); wb_allowin = 1;
        wait_drain("inorder_drain");

        // cancel with two waiting loads; both responses dropped, add meanwhile
        step(); enq(30, 32'h3000, 4'b0010, 0, 0);
        step(); enq(31, 32'h3004, 4'b0010, 0, 0);
        step(); idle(); cancel = 1;
        step(); cancel = 0;
        @(negedge clk);
        chk("cancel_valid", mem_to_wb_valid, 0);
        chk("cancel_pending", mem_fwd_pending, 0);
        chk("cancel_allowin", mem_allowin, 1);
        chk("cancel_discard2", dut.discard, 2);
        step(); data_ok = 1; rdata = 32'hDEAD;
        enq(32, 32'h1234_5678, 4'b0000, 0, 0); push(32, 32'h1234_5678, 0);
        step(); idle(); rdata = 32'hBEEF;
        step(); data_ok = 0;
        @(negedge clk);
        chk("discard_spent", dut.discard, 0);
        chk("discard_no_err", dut.dbg_err, 0);
        wait_drain("add_during_discard");

        // cancel coincident with data_ok for head load
        step(); enq(40, 32'h4000, 4'b0010, 0, 0);
        step(); enq(41, 32'h4004, 4'b0010, 0, 0);
        step(); idle(); data_ok = 1; rdata = 32'h33; cancel = 1;
        step(); data_ok = 0; cancel = 0;
        @(negedge clk);
        chk("cancel_ok_discard1", dut.discard, 1);
        chk("cancel_ok_valid", mem_to_wb_valid, 0);
        step(); data_ok = 1; rdata = 32'h44;
        step(); data_ok = 0;
        @(negedge clk);
        chk("cancel_ok_discard0", dut.discard, 0);
        chk("cancel_ok_no_err", dut.dbg_err, 0);

        // excepting load does not wait
        step(); enq(50, 32'h5001, 4'b0010, 0, 7'h20); push(50, 32'h5001, 7'h20);
        step(); idle();
        @(negedge clk);
        chk("exc_flush", mem_exc_flush, 1);
        chk("exc_pending", mem_fwd_pending, 0);
        wait_drain("exc_drain");

        // store waits for data_ok but is not a forwarding hazard
        step(); enq(60, 32'h55AA, 4'b0000, 1, 0);
        step(); idle();
        @(negedge clk);
        chk("st_wait_valid", mem_to_wb_valid, 0);
        chk("st_pending", mem_fwd_pending, 0);
        step(); data_ok = 1; rdata = 32'h9999; push(60, 32'h55AA, 0);
        step(); data_ok = 0;
        wait_drain("st_drain");

        // asynchronous reset while full
        wb_allowin = 0;
        step(); enq(70, 32'h7000, 4'b0000, 0, 0);
        step(); enq(71, 32'h7004, 4'b0000, 0, 0);
        step(); idle();
        @(negedge clk);
        chk("prerst_allowin", mem_allowin, 0);
        chk("prerst_valid", mem_to_wb_valid, 1);
        #2 resetn = 0;
        #1;
        chk("arst_allowin", mem_allowin, 1);
        chk("arst_valid", mem_to_wb_valid, 0);
        chk("arst_info", mem_info, 0);
        chk("arst_wdata", mem_wdata, 0);
        step(); resetn = 1; wb_allowin = 1;
        step(); step();
        @(negedge clk);
        chk("post_rst_valid", mem_to_wb_valid, 0);
        chk("end_queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
